// File: rtl/cv32e40s_alert_escalation.sv
// cv32e40s_alert_escalation: classifies hardening errors as major/minor, leaks a minor-event bucket, escalates to the controller via req/ack and locks until reset
module cv32e40s_alert_escalation #(
  parameter int MINOR_THRESHOLD = 4,
  parameter int DECAY_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pc_err_i,
  input  logic       csr_err_i,
  input  logic       itf_int_err_i,
  input  logic       rf_ecc_err_i,
  input  logic       lfsr_lockup_i,
  input  logic       bus_fault_i,
  input  logic       escalate_ack_i,
  output logic       alert_major_o,
  output logic       alert_minor_o,
  output logic       escalate_req_o,
  output logic [4:0] err_cause_o,
  output logic [3:0] minor_cnt_o,
  output logic       locked_o
);
  typedef enum logic [1:0] {IDLE, ESC_REQ, LOCKED} state_e;
  localparam logic [3:0]  TH = 4'(MINOR_THRESHOLD);
  localparam logic [15:0] DC = 16'(DECAY_CYCLES - 1);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tmr_q, tmr_d;
  logic [4:0]  cause_q, cause_d;
  logic        major_q, major_d, req_q, req_d, lock_q, lock_d, minor_q, minor_d;
  logic        idle, major_hit, minor_hit, promo, decay, esc;
  always_comb begin
    idle      = state_q == IDLE;
    major_hit = pc_err_i | csr_err_i | itf_int_err_i | rf_ecc_err_i;
    minor_hit = lfsr_lockup_i | bus_fault_i;
    promo     = idle && minor_hit && (cnt_q + 4'd1 == TH);
    decay     = idle && !minor_hit && cnt_q != 4'd0 && tmr_q == DC;
    esc       = idle && (major_hit || promo);
    cnt_d     = !idle ? cnt_q : minor_hit ? cnt_q + 4'd1 : decay ? cnt_q - 4'd1 : cnt_q;
    tmr_d     = !idle ? tmr_q : (minor_hit || decay || cnt_q == 4'd0) ? 16'd0 : tmr_q + 16'd1;
    state_d   = esc ? ESC_REQ : (state_q == ESC_REQ && escalate_ack_i) ? LOCKED : state_q;
    cause_d   = esc ? {promo, rf_ecc_err_i, itf_int_err_i, csr_err_i, pc_err_i} : cause_q;
    major_d   = state_d != IDLE;
    req_d     = state_d == ESC_REQ;
    lock_d    = state_d == LOCKED;
    minor_d   = minor_hit;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      cause_q <= '0;
      major_q <= 1'b0;
      req_q   <= 1'b0;
      lock_q  <= 1'b0;
      minor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      cause_q <= cause_d;
      major_q <= major_d;
      req_q   <= req_d;
      lock_q  <= lock_d;
      minor_q <= minor_d;
    end
  end
  assign alert_major_o  = major_q;
  assign alert_minor_o  = minor_q;
  assign escalate_req_o = req_q;
  assign err_cause_o    = cause_q;
  assign minor_cnt_o    = cnt_q;
  assign locked_o       = lock_q;
endmodule

// File: tb/tb_cv32e40s_alert_escalation.sv
// tb_cv32e40s_alert_escalation: directed checks of escalation, promotion, decay and reset
module tb_cv32e40s_alert_escalation;
  logic clk = 1'b0, rst_n = 1'b0;
  logic pc, csr, itf, rf, lfsr, bus, ack;
  logic major, minor, req, locked;
  logic [4:0] cause;
  logic [3:0] cnt;
  int pass = 0, total = 0;
  cv32e40s_alert_escalation #(.MINOR_THRESHOLD(4), .DECAY_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .pc_err_i(pc), .csr_err_i(csr), .itf_int_err_i(itf),
    .rf_ecc_err_i(rf), .lfsr_lockup_i(lfsr), .bus_fault_i(bus), .escalate_ack_i(ack),
    .alert_major_o(major), .alert_minor_o(minor), .escalate_req_o(req),
    .err_cause_o(cause), .minor_cnt_o(cnt), .locked_o(locked));
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    {pc, csr, itf, rf, lfsr, bus, ack} = '1;
    rst_n = 1'b0;
    step(2);
    total++; if ({major, minor, req, cause, cnt, locked} !== 13'd0) $display("FAIL reset outs got %b exp 0", {major, minor, req, cause, cnt, locked}); else pass++;
    {pc, csr, itf, rf, lfsr, bus, ack} = '0;
    rst_n = 1'b1;
    step();
    total++; if ({major, minor, req, cause, cnt, locked} !== 13'd0) $display("FAIL idle outs got %b exp 0", {major, minor, req, cause, cnt, locked}); else pass++;
  endtask
  task automatic test_major;
    do_reset();
    step(9);
    pc = 1'b1;
    step();
    pc = 1'b0;
    total++; if ({major, req, locked} !== 3'b110) $display("FAIL major esc got %b exp 110", {major, req, locked}); else pass++;
    total++; if (cause !== 5'b00001) $display("FAIL major cause got %b exp 00001", cause); else pass++;
    step(3);
    total++; if ({major, req, locked} !== 3'b110) $display("FAIL req hold got %b exp 110", {major, req, locked}); else pass++;
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++; if ({major, req, locked} !== 3'b101) $display("FAIL lock got %b exp 101", {major, req, locked}); else pass++;
    csr = 1'b1;
    bus = 1'b1;
    ack = 1'b1;
    step();
    {csr, bus, ack} = '0;
    total++; if ({major, req, locked, cause, cnt} !== {3'b101, 5'b00001, 4'd0}) $display("FAIL locked frozen got %b exp 101000010000", {major, req, locked, cause, cnt}); else pass++;
    total++; if (minor !== 1'b1) $display("FAIL locked minor pulse got %b exp 1", minor); else pass++;
  endtask
  task automatic test_simultaneous;
    do_reset();
    csr = 1'b1;
    rf = 1'b1;
    step();
    {csr, rf} = '0;
    total++; if (cause !== 5'b01010 || req !== 1'b1) $display("FAIL simul cause got %b/%b exp 01010/1", cause, req); else pass++;
    itf = 1'b1;
    step();
    itf = 1'b0;
    total++; if (cause !== 5'b01010 || req !== 1'b1) $display("FAIL late err got %b/%b exp 01010/1", cause, req); else pass++;
  endtask
  task automatic test_threshold;
    int pulses = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      bus = 1'b1;
      step();
      bus = 1'b0;
      total++; if (cnt !== 4'(i) || req !== (i == 4)) $display("FAIL thresh ev%0d cnt/req got %0d/%b exp %0d/%b", i, cnt, req, i, i == 4); else pass++;
      pulses += int'(minor);
      for (int j = 0; j < 4; j++) begin
        step();
        pulses += int'(minor);
      end
    end
    total++; if (pulses !== 4) $display("FAIL minor pulses got %0d exp 4", pulses); else pass++;
    total++; if ({major, req, cause} !== {2'b11, 5'b10000}) $display("FAIL promo cause got %b exp 1110000", {major, req, cause}); else pass++;
    lfsr = 1'b1;
    step();
    lfsr = 1'b0;
    total++; if (cnt !== 4'd4 || minor !== 1'b1) $display("FAIL esc cnt frozen got %0d/%b exp 4/1", cnt, minor); else pass++;
  endtask
  task automatic test_decay;
    do_reset();
    bus = 1'b1;
    step();
    bus = 1'b0;
    total++; if (cnt !== 4'd1) $display("FAIL decay start got %0d exp 1", cnt); else pass++;
    step(7);
    total++; if (cnt !== 4'd1) $display("FAIL decay early got %0d exp 1", cnt); else pass++;
    step();
    total++; if (cnt !== 4'd0) $display("FAIL decay point got %0d exp 0", cnt); else pass++;
    step(20);
    bus = 1'b1;
    step();
    bus = 1'b0;
    step(7);
    bus = 1'b1;
    step();
    bus = 1'b0;
    total++; if (cnt !== 4'd2) $display("FAIL collide got %0d exp 2", cnt); else pass++;
    step(7);
    total++; if (cnt !== 4'd2) $display("FAIL restart early got %0d exp 2", cnt); else pass++;
    step();
    total++; if (cnt !== 4'd1) $display("FAIL restart dec got %0d exp 1", cnt); else pass++;
    step(8);
    total++; if (cnt !== 4'd0) $display("FAIL second dec got %0d exp 0", cnt); else pass++;
  endtask
  task automatic test_same_cycle;
    do_reset();
    lfsr = 1'b1;
    bus = 1'b1;
    step();
    {lfsr, bus} = '0;
    total++; if (cnt !== 4'd1 || minor !== 1'b1) $display("FAIL both minors got %0d/%b exp 1/1", cnt, minor); else pass++;
    step();
    total++; if (cnt !== 4'd1 || minor !== 1'b0) $display("FAIL single pulse got %0d/%b exp 1/0", cnt, minor); else pass++;
  endtask
  task automatic test_back_to_back;
    bus = 1'b1;
    step();
    total++; if (cnt !== 4'd2 || minor !== 1'b1) $display("FAIL b2b first got %0d/%b exp 2/1", cnt, minor); else pass++;
    step();
    bus = 1'b0;
    total++; if (cnt !== 4'd3 || minor !== 1'b1 || req !== 1'b0) $display("FAIL b2b second got %0d/%b/%b exp 3/1/0", cnt, minor, req); else pass++;
  endtask
  task automatic test_reset_mid;
    do_reset();
    pc = 1'b1;
    step();
    pc = 1'b0;
    total++; if (req !== 1'b1) $display("FAIL mid req got %b exp 1", req); else pass++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if ({major, minor, req, cause, cnt, locked} !== 13'd0) $display("FAIL mid reset got %b exp 0", {major, minor, req, cause, cnt, locked}); else pass++;
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++; if ({req, locked} !== 2'b00) $display("FAIL idle ack got %b exp 00", {req, locked}); else pass++;
    pc = 1'b1;
    step();
    pc = 1'b0;
    total++; if ({major, req, locked, cause} !== {3'b110, 5'b00001}) $display("FAIL re-esc got %b exp 11000001", {major, req, locked, cause}); else pass++;
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++; if ({major, req, locked} !== 3'b101) $display("FAIL early ack got %b exp 101", {major, req, locked}); else pass++;
  endtask
  initial begin
    {pc, csr, itf, rf, lfsr, bus, ack} = '0;
    test_reset();
    test_major();
    test_simultaneous();
    test_threshold();
    test_decay();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
